vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 132 +++++++++++++
 tb/tb_vga_scanout.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: 800x525 raster timing with a framebuffer window and a 3-stage pixel pipeline.
// Define VGA_SCANOUT_BORDER_EN to paint visible pixels outside the window with BORDER_RGB.
module vga_scanout #(
   parameter int unsigned H_VIS      = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_VIS      = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned FB_W       = 256,
   parameter int unsigned FB_H       = 256,
   parameter int unsigned X0         = 192,
   parameter int unsigned Y0         = 112,
   parameter logic [7:0]  BORDER_RGB = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] r_addr,
   input  logic [7:0]  rd,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        frame_start
);

   localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW     = $clog2(H_TOT);
   localparam int unsigned VW     = $clog2(V_TOT);
   localparam int unsigned HS_BEG = H_VIS + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_VIS + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC;

`ifdef VGA_SCANOUT_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif
   // With the border feature off, off-window pixels collapse to black.
   localparam logic [7:0] BORDER_PX = BORDER_EN ? BORDER_RGB : 8'h00;

   function automatic logic [23:0] expand(input logic [7:0] p);
      return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
   endfunction

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          armed_q;
   logic [31:0]   h_ext, v_ext;
   logic          in_win_c, vis_c, hs_n_c, vs_n_c, fs_c;
   logic          s1_win_q, s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q;
   logic [23:0]   rgb_d;

   // S0: raster counters
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOT - 1)) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VW'(V_TOT - 1)) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // S0: position decode and framebuffer address
   always_comb begin
      h_ext    = 32'(h_cnt_q);
      v_ext    = 32'(v_cnt_q);
      in_win_c = (h_ext >= X0) && (h_ext < X0 + FB_W) && (v_ext >= Y0) && (v_ext < Y0 + FB_H);
      vis_c    = (h_ext < H_VIS) && (v_ext < V_VIS);
      hs_n_c   = !((h_ext >= HS_BEG) && (h_ext < HS_END));
      vs_n_c   = !((v_ext >= VS_BEG) && (v_ext < VS_END));
      // armed_q masks the (0,0) seen straight out of reset
      fs_c     = armed_q && (h_cnt_q == '0) && (v_cnt_q == '0);
      r_addr   = in_win_c ? (v_ext - Y0) * FB_W + (h_ext - X0) : '0;
   end

   // S1 -> S2: colour select; rd is only looked at for window pixels
   always_comb begin
      rgb_d = '0;
      if (s1_vis_q) rgb_d = expand(s1_win_q ? rd : BORDER_PX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         armed_q  <= 1'b0;
         s1_win_q <= 1'b0;
         s1_vis_q <= 1'b0;
         s1_hs_q  <= 1'b1;
         s1_vs_q  <= 1'b1;
         s1_fs_q  <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         armed_q  <= 1'b1;
         s1_win_q <= in_win_c;
         s1_vis_q <= vis_c;
         s1_hs_q  <= hs_n_c;
         s1_vs_q  <= vs_n_c;
         s1_fs_q  <= fs_c;
      end
   end

   // S2: registered DAC and sync outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= rgb_d[23:16];
         vga_g       <= rgb_d[15:8];
         vga_b       <= rgb_d[7:0];
         vga_hs      <= s1_hs_q;
         vga_vs      <= s1_vs_q;
         vga_blank_n <= s1_vis_q;
         frame_start <= s1_fs_q;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster; reference model derives everything from the cycle count.
`timescale 1ns/1ps
module tb_vga_scanout;

   localparam int unsigned H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 6;
   localparam int unsigned V_VIS = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int unsigned FB_W = 16, FB_H = 8, X0 = 10, Y0 = 6;
   localparam logic [7:0]  BORDER = 8'h1C;
   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned FRAME = H_TOT * V_TOT;
   localparam int unsigned FBN   = FB_W * FB_H;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       bn;
      logic       fs;
   } exp_t;

   localparam exp_t RST = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0, fs: 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rd = 8'h00;
   logic [31:0] r_addr;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, frame_start;

   logic [7:0]  mem [FBN];
   exp_t        q [$];
   bit          mon_en = 1'b0;
   int unsigned t = 0;
   int unsigned mon_t = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   vga_scanout #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .FB_W(FB_W), .FB_H(FB_H), .X0(X0), .Y0(Y0), .BORDER_RGB(BORDER)
   ) dut (
      .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .rd(rd),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .frame_start(frame_start)
   );

   always #20 clk = ~clk;

   // Bit replication written as arithmetic: x * 0b1001001 repeats a 3-bit field.
   function automatic logic [7:0] ex3(input logic [2:0] x);
      return 8'((32'(x) * 32'd73) >> 1);
   endfunction

   function automatic logic [7:0] ex2(input logic [1:0] x);
      return 8'(32'(x) * 32'd85);
   endfunction

   function automatic exp_t model(input int unsigned tc, output int unsigned addr, output bit win);
      exp_t        e;
      int unsigned h, v;
      logic [7:0]  p;
      h    = tc % H_TOT;
      v    = (tc / H_TOT) % V_TOT;
      win  = (h >= X0) && (h < X0 + FB_W) && (v >= Y0) && (v < Y0 + FB_H);
      addr = win ? (v - Y0) * FB_W + (h - X0) : 0;
      e    = '0;
      e.hs = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
      e.vs = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
      e.bn = (h < H_VIS) && (v < V_VIS);
      e.fs = (tc > 0) && (tc % FRAME == 0);
`ifdef VGA_SCANOUT_BORDER_EN
      p = BORDER;
`else
      p = 8'h00;
`endif
      if (win) p = mem[addr];
      if (e.bn) begin
         e.r = ex3(p[7:5]);
         e.g = ex3(p[4:2]);
         e.b = ex2(p[1:0]);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int unsigned tc);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %h exp %h", name, tc, got, exp);
      end
   endtask

   task automatic check_reset();
      check("reset_outputs", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start}), 32'(RST), t);
      check("reset_r_addr", r_addr, 32'd0, t);
   endtask

   // Called on a falling edge while reset is held.
   task automatic release_reset();
      rst_n = 1'b1;
      t     = 0;
      mon_t = 0;
      q.delete();
      q.push_back(RST);
      q.push_back(RST);
      mon_en = 1'b1;
   endtask

   task automatic run(input int unsigned n);
      exp_t        e;
      int unsigned a;
      bit          w;
      for (int unsigned i = 0; i < n; i++) begin
         #1;
         e = model(t, a, w);
         check("r_addr", r_addr, 32'(a), t);
         q.push_back(e);
         @(posedge clk);
         #1;
         rd = w ? mem[a] : 8'($urandom);
         t++;
         @(negedge clk);
      end
   endtask

   // Monitor: one registered output word per cycle, compared against the queue head.
   always @(negedge clk) begin : monitor
      exp_t e;
      #2;
      if (mon_en) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow t=%0d got empty exp entry", mon_t);
         end else begin
            e = q.pop_front();
            check("outputs", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start}),
                  32'(e), mon_t);
         end
         mon_t++;
      end
   end

   initial begin
      for (int unsigned i = 0; i < FBN; i++) mem[i] = 8'($urandom);
      mem[0]   = 8'hE0;
      mem[FBN-1] = 8'h03;

      repeat (3) @(negedge clk);
      #1 check_reset();
      @(negedge clk);
      release_reset();
      run(2 * FRAME + 7 * H_TOT + 12);

      // Mid-frame reset with the raster inside the window.
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1 check_reset();
      repeat (3) begin
         @(posedge clk);
         #1 rd = 8'($urandom);
         check_reset();
      end
      @(negedge clk);
      release_reset();
      run(FRAME + 3 * H_TOT);

      mon_en = 1'b0;
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
